// File: rtl/move_stream_pkg.sv
// Shared constants and state encoding for the move_stream sequencer.
package move_stream_pkg;

    localparam int PIECE_BITS    = 4;
    localparam int MAX_POSITIONS = 256;
    localparam int LAT_WIDTH     = 4;

    localparam logic [PIECE_BITS-1:0] EMPTY_POSN = 4'h0;
    localparam logic [3:0]            EP_NONE    = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_FETCH,
        ST_PRESENT,
        ST_CLEAR,
        ST_DONE
    } ms_state_e;

endpackage

// File: rtl/move_stream.sv
// Walks the all_moves list once per start, streaming each child position
// over valid/ready and clearing all_moves when the walk ends.
module move_stream
    import move_stream_pkg::*;
#(
    parameter int PIECE_WIDTH        = PIECE_BITS,
    parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH        = SIDE_WIDTH * 8,
    parameter int MAX_POSITIONS      = move_stream_pkg::MAX_POSITIONS,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int READ_LATENCY       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          clear_moves,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BOARD_WIDTH-1:0]        out_board,
    output logic                          out_white_to_move,
    output logic [3:0]                    out_castle_mask,
    output logic [3:0]                    out_en_passant_col,
    output logic [MAX_POSITIONS_LOG2-1:0] out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_POSITIONS_LOG2-1:0] streamed
);

    localparam int IW = MAX_POSITIONS_LOG2;
    localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD =
        {(BOARD_WIDTH / PIECE_WIDTH){PIECE_WIDTH'(EMPTY_POSN)}};

    ms_state_e              state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          move_index_q, move_index_d;
    logic [LAT_WIDTH-1:0]   lat_q, lat_d;
    logic [IW-1:0]          streamed_q, streamed_d;
    logic [IW-1:0]          out_index_q, out_index_d;
    logic                   out_last_q, out_last_d;
    logic [BOARD_WIDTH-1:0] out_board_q, out_board_d;
    logic                   out_wtm_q, out_wtm_d;
    logic [3:0]             out_castle_q, out_castle_d;
    logic [3:0]             out_ep_q, out_ep_d;
    logic                   out_valid_q, out_valid_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        move_index_d = move_index_q;
        lat_d        = lat_q;
        streamed_d   = streamed_q;
        out_index_d  = out_index_q;
        out_last_d   = out_last_q;
        out_board_d  = out_board_q;
        out_wtm_d    = out_wtm_q;
        out_castle_d = out_castle_q;
        out_ep_d     = out_ep_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_READY;
                    streamed_d = '0;
                end
            end
            ST_WAIT_READY: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (moves_ready) begin
                    cnt_d = move_count;
                    if (move_count == '0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        move_index_d = '0;
                        lat_d        = LAT_WIDTH'(READ_LATENCY);
                        state_d      = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (lat_q == LAT_WIDTH'(1)) begin
                    // board_in is valid on the last FETCH cycle; capture it there.
                    out_board_d  = board_in;
                    out_wtm_d    = white_to_move_in;
                    out_castle_d = castle_mask_in;
                    out_ep_d     = en_passant_col_in;
                    out_index_d  = move_index_q;
                    out_last_d   = (move_index_q == cnt_q - IW'(1));
                    state_d      = ST_PRESENT;
                end else begin
                    lat_d = lat_q - LAT_WIDTH'(1);
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (out_ready) begin
                    streamed_d = streamed_q + IW'(1);
                    if (out_last_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        move_index_d = move_index_q + IW'(1);
                        lat_d        = LAT_WIDTH'(READ_LATENCY);
                        state_d      = ST_FETCH;
                    end
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        out_valid_d = (state_d == ST_PRESENT);
        clear_d     = (state_d == ST_CLEAR);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            move_index_q <= '0;
            lat_q        <= '0;
            streamed_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_board_q  <= EMPTY_BOARD;
            out_wtm_q    <= 1'b1;
            out_castle_q <= '0;
            out_ep_q     <= EP_NONE;
            out_valid_q  <= 1'b0;
            clear_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            move_index_q <= move_index_d;
            lat_q        <= lat_d;
            streamed_q   <= streamed_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
            out_board_q  <= out_board_d;
            out_wtm_q    <= out_wtm_d;
            out_castle_q <= out_castle_d;
            out_ep_q     <= out_ep_d;
            out_valid_q  <= out_valid_d;
            clear_q      <= clear_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign move_index         = move_index_q;
    assign clear_moves        = clear_q;
    assign out_valid          = out_valid_q;
    assign out_board          = out_board_q;
    assign out_white_to_move  = out_wtm_q;
    assign out_castle_mask    = out_castle_q;
    assign out_en_passant_col = out_ep_q;
    assign out_index          = out_index_q;
    assign out_last           = out_last_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign streamed           = streamed_q;

endmodule

// File: tb/tb_move_stream.sv
// Directed bench for move_stream: a READ_LATENCY=1 instance (a) and a
// READ_LATENCY=3 instance (b), each fed by a small all_moves model.
module tb_move_stream;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         abort = 1'b0;
    logic         moves_ready = 1'b0;
    logic [7:0]   move_count = '0;
    logic         out_ready = 1'b1;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;

    logic [7:0]   mi_a, oi_a, st_a, mi_b, oi_b, st_b;
    logic [255:0] bi_a, ob_a, bi_b, ob_b;
    logic         wi_a, wi_b, ow_a, ow_b;
    logic [3:0]   ci_a, ci_b, oc_a, oc_b, ei_a, ei_b, oe_a, oe_b;
    logic         clr_a, ov_a, ol_a, busy_a, done_a;
    logic         clr_b, ov_b, ol_b, busy_b, done_b;
    logic [7:0]   p1, p2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [255:0] board_of(input logic [7:0] i);
        return {32{i ^ 8'h5A}};
    endfunction

    // Instance a: zero-stage model (board valid in the cycle move_index changes).
    always_comb begin
        bi_a = board_of(mi_a);
        wi_a = mi_a[0];
        ci_a = mi_a[3:0] ^ 4'hF;
        ei_a = {1'b0, mi_a[2:0]};
    end

    // Instance b: two pipeline stages, so data is valid on the 3rd cycle.
    always @(posedge clk) begin
        p1 <= mi_b;
        p2 <= p1;
    end
    always_comb begin
        bi_b = board_of(p2);
        wi_b = p2[0];
        ci_b = p2[3:0] ^ 4'hF;
        ei_b = {1'b0, p2[2:0]};
    end

    move_stream #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset_n), .start(start_a), .abort(abort),
        .moves_ready(moves_ready), .move_count(move_count),
        .board_in(bi_a), .white_to_move_in(wi_a), .castle_mask_in(ci_a),
        .en_passant_col_in(ei_a), .move_index(mi_a), .clear_moves(clr_a),
        .out_valid(ov_a), .out_ready(out_ready), .out_board(ob_a),
        .out_white_to_move(ow_a), .out_castle_mask(oc_a),
        .out_en_passant_col(oe_a), .out_index(oi_a), .out_last(ol_a),
        .busy(busy_a), .done(done_a), .streamed(st_a)
    );

    move_stream #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset_n), .start(start_b), .abort(abort),
        .moves_ready(moves_ready), .move_count(move_count),
        .board_in(bi_b), .white_to_move_in(wi_b), .castle_mask_in(ci_b),
        .en_passant_col_in(ei_b), .move_index(mi_b), .clear_moves(clr_b),
        .out_valid(ov_b), .out_ready(out_ready), .out_board(ob_b),
        .out_white_to_move(ow_b), .out_castle_mask(oc_b),
        .out_en_passant_col(oe_b), .out_index(oi_b), .out_last(ol_b),
        .busy(busy_b), .done(done_b), .streamed(st_b)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".busy"}, busy_a, 0);
        check({tag, ".valid"}, ov_a, 0);
        check({tag, ".clear"}, clr_a, 0);
        check({tag, ".done"}, done_a, 0);
        check({tag, ".last"}, ol_a, 0);
        check({tag, ".mi"}, mi_a, 0);
        check({tag, ".oi"}, oi_a, 0);
        check({tag, ".streamed"}, st_a, 0);
        check({tag, ".board"}, ob_a, 0);
        check({tag, ".wtm"}, ow_a, 1);
        check({tag, ".castle"}, oc_a, 0);
        check({tag, ".ep"}, oe_a, 4'b1000);
    endtask

    initial begin
        logic [255:0] held;

        // Reset
        step(); step();
        check_reset_a("rst");
        check("rst.b_busy", busy_b, 0);
        reset_n = 1'b1;
        moves_ready = 1'b1;

        // Walk of 3 with out_ready high
        move_count = 8'd3;
        start_a = 1'b1; step(); start_a = 1'b0;
        check("w3.busy", busy_a, 1);
        step();
        check("w3.fetch_mi", mi_a, 0);
        check("w3.fetch_valid", ov_a, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("w3.valid", ov_a, 1);
            check("w3.oi", oi_a, i);
            check("w3.board", ob_a, board_of(8'(i)));
            check("w3.wtm", ow_a, i & 1);
            check("w3.castle", oc_a, 4'(i) ^ 4'hF);
            check("w3.ep", oe_a, {1'b0, 3'(i)});
            check("w3.last", ol_a, i == 2);
            step();
            check("w3.drop", ov_a, 0);
            check("w3.streamed", st_a, i + 1);
            if (i < 2) check("w3.mi", mi_a, i + 1);
        end
        check("w3.clear", clr_a, 1);
        step();
        check("w3.clear_gone", clr_a, 0);
        check("w3.done", done_a, 1);
        step();
        check("w3.idle_done", done_a, 0);
        check("w3.idle_busy", busy_a, 0);

        // Backpressure on beat 1
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step(); step();   // WAIT, FETCH0, PRESENT0, handshake
        step();                   // PRESENT1
        check("bp.valid1", ov_a, 1);
        held = ob_a;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_valid", ov_a, 1);
            check("bp.hold_oi", oi_a, 1);
            check("bp.hold_board", ob_a, held);
            check("bp.hold_mi", mi_a, 1);
            check("bp.hold_streamed", st_a, 1);
        end
        out_ready = 1'b1;
        step();
        check("bp.accept_streamed", st_a, 2);
        check("bp.accept_mi", mi_a, 2);
        step();
        check("bp.beat2_oi", oi_a, 2);
        step();
        check("bp.clear", clr_a, 1);
        check("bp.streamed", st_a, 3);
        step(); step();
        check("bp.idle", busy_a, 0);

        // Empty list
        move_count = 8'd0;
        start_a = 1'b1; step(); start_a = 1'b0;
        step();
        check("empty.clear", clr_a, 1);
        check("empty.valid", ov_a, 0);
        step();
        check("empty.done", done_a, 1);
        check("empty.streamed", st_a, 0);
        step();
        check("empty.idle", busy_a, 0);

        // Abort with out_ready in the same cycle during beat 1
        move_count = 8'd3;
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step(); step(); step();
        check("ab.valid1", ov_a, 1);
        check("ab.oi", oi_a, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab.clear", clr_a, 1);
        check("ab.valid_drop", ov_a, 0);
        check("ab.streamed", st_a, 1);
        step();
        check("ab.done", done_a, 1);
        step();
        check("ab.idle", busy_a, 0);

        // Reset mid-FETCH after one accepted beat
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step(); step();
        check("rf.fetch_mi", mi_a, 1);
        check("rf.fetch_streamed", st_a, 1);
        reset_n = 1'b0;
        step();
        check_reset_a("rf");
        reset_n = 1'b1;
        step();
        check("rf.no_clear", clr_a, 0);
        check("rf.no_done", done_a, 0);

        // Restart after reset: single-move list
        move_count = 8'd1;
        start_a = 1'b1; step(); start_a = 1'b0;
        step(); step();
        check("rs.valid", ov_a, 1);
        check("rs.last", ol_a, 1);
        step();
        check("rs.clear", clr_a, 1);
        check("rs.streamed", st_a, 1);
        step();
        check("rs.done", done_a, 1);
        step();

        // READ_LATENCY=3, two moves, with a start pulse while busy
        move_count = 8'd2;
        start_b = 1'b1; step(); start_b = 1'b0;
        step();
        check("l3.mi0", mi_b, 0);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        check("l3.wait1", ov_b, 0);
        step();
        check("l3.wait2", ov_b, 0);
        step();
        check("l3.valid0", ov_b, 1);
        check("l3.board0", ob_b, board_of(8'd0));
        check("l3.castle0", oc_b, 4'hF);
        check("l3.last0", ol_b, 0);
        step();
        check("l3.mi1", mi_b, 1);
        check("l3.drop", ov_b, 0);
        step();
        check("l3.wait1b", ov_b, 0);
        step();
        check("l3.wait2b", ov_b, 0);
        step();
        check("l3.valid1", ov_b, 1);
        check("l3.board1", ob_b, board_of(8'd1));
        check("l3.wtm1", ow_b, 1);
        check("l3.oi1", oi_b, 1);
        check("l3.last1", ol_b, 1);
        step();
        check("l3.clear", clr_b, 1);
        check("l3.streamed", st_b, 2);
        step();
        check("l3.done", done_b, 1);
        step();
        check("l3.idle", busy_b, 0);
        step();
        check("l3.no_restart", busy_b, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_stream.md
Name: move_stream

Overview:
- Sequencer between all_moves and downstream consumers (evaluator, display, next-ply all_moves).
- After a move list is generated, it walks move_index from 0 to move_count-1 and captures each child position, with the all_moves read latency set by a parameter.
- Streams each child position out over a valid/ready handshake with index and last flags.
- Ends the walk by pulsing clear_moves, so all_moves is driven by hardware instead of a bench.

Parameters:
PIECE_WIDTH, 4, bits per square (matches PIECE_BITS)
SIDE_WIDTH, PIECE_WIDTH*8, bits per rank
BOARD_WIDTH, PIECE_WIDTH*64, bits per board
MAX_POSITIONS, 256, move-list capacity of all_moves
MAX_POSITIONS_LOG2, 8, clog2(MAX_POSITIONS); width of counts and indices
READ_LATENCY, 1, cycles from a move_index change to valid board_in; legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  request a walk; sampled only in IDLE
abort  in  1  terminate the walk early
moves_ready  in  1  from all_moves: list complete
move_count  in  MAX_POSITIONS_LOG2  from all_moves: number of legal moves
board_in  in  BOARD_WIDTH  all_moves board_out at move_index
white_to_move_in  in  1  all_moves white_to_move_out
castle_mask_in  in  4  all_moves castle_mask_out
en_passant_col_in  in  4  all_moves en_passant_col_out
move_index  out  MAX_POSITIONS_LOG2  to all_moves
clear_moves  out  1  to all_moves; one-cycle pulse
out_valid  out  1  child position valid
out_ready  in  1  consumer accepts
out_board  out  BOARD_WIDTH  child board
out_white_to_move  out  1  child side to move
out_castle_mask  out  4  child castle mask
out_en_passant_col  out  4  child en-passant column (bit 3 = none)
out_index  out  MAX_POSITIONS_LOG2  index of this child
out_last  out  1  this child is index move_count-1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of walk
streamed  out  MAX_POSITIONS_LOG2  children accepted in the last or current walk

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - move_index, out_index, streamed, latency counter = 0.
  - out_valid, out_last, clear_moves, done, busy = 0.
  - out_board = all EMPTY_POSN; out_castle_mask = 0; out_en_passant_col = 4'b1000; out_white_to_move = 1.
  - Reset wins over every other input, including mid-handshake; no clear_moves is issued on reset.
- IDLE: start=1 -> WAIT_READY and streamed<=0. All other inputs are ignored.
- WAIT_READY: moves_ready=1 -> latch move_count into cnt.
  - If cnt==0 -> CLEAR.
  - Else move_index<=0, latency counter<=READ_LATENCY, -> FETCH.
- FETCH: counter decrements by 1 per cycle.
  - On the cycle the counter==1: capture board_in and its side fields into the out_* registers; out_index<=move_index; out_last<=(move_index==cnt-1); -> PRESENT.
  - FETCH therefore lasts exactly READ_LATENCY cycles.
- PRESENT: out_valid=1, and all out_* are held stable until out_ready.
  - On out_valid&&out_ready: streamed<=streamed+1 and out_valid drops the next cycle.
  - Then: out_last -> CLEAR; else move_index<=move_index+1 and counter<=READ_LATENCY, -> FETCH.
- CLEAR: clear_moves=1 for exactly one cycle -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- abort=1 in WAIT_READY, FETCH or PRESENT -> CLEAR next cycle; out_valid drops. abort has priority over out_ready in the same cycle, so that child is not counted. abort in CLEAR, DONE or IDLE is ignored.
- Latency: with moves_ready sampled at edge k, move_index=0 after edge k and out_valid rises after edge k+READ_LATENCY.
- Throughput with out_ready tied high: one child per READ_LATENCY+1 cycles.
- move_index never exceeds cnt-1. streamed cannot wrap, because cnt<=MAX_POSITIONS-1.
- start asserted while busy is ignored; there is no queued restart.

Decomposition:
- Shared package/header (vchess.vh): PIECE_BITS, EMPTY_POSN, MAX_POSITIONS, the en-passant "none" encoding 4'b1000, and the move_stream state encoding localparams.
- No sub-module needed. The latency counter and the FSM fit in one module.

Test Plan:
- move_count=3, READ_LATENCY=1, out_ready=1:
  - move_index steps 0,1,2; three out_valid beats with out_index 0,1,2 and out_last only on 2.
  - clear_moves pulses once, then done one cycle later; streamed=3.
- Backpressure: out_ready low for 5 cycles during beat 1 -> out_valid stays high, out_board/out_index stay stable, move_index stays at 1, no extra beat.
- move_count=0 -> no out_valid; clear_moves at WAIT_READY+1, done the cycle after; streamed=0.
- abort during PRESENT of beat 1 with out_ready=1 in the same cycle -> beat not counted (streamed=1); clear_moves next cycle, then done.
- reset driven low mid-FETCH -> next cycle state=IDLE, all outputs at reset values, no clear_moves/done; a subsequent start works normally.
- READ_LATENCY=3, move_count=2:
  - out_valid rises 3 cycles after each move_index change; out_board equals the all_moves board_out for that index.
  - A start pulse issued while busy has no effect.
